// File: rtl/pci_config_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pci_config_target                                             |
// | Purpose  : PCI Type-0 configuration-space target. Claims single-phase    |
// |            Configuration Read (CBE=1010) / Write (CBE=1011) cycles when  |
// |            IDSEL is high, drives DEVSEL/TRDY/STOP and read data on AD,   |
// |            and holds the bridge's configuration header registers.        |
// | Ports    : clk, rst_n (sync, active low)                                 |
// |            FRAME, IRDY, IDSEL, CBE[3:0], AD_in[31:0]  - bus inputs       |
// |            AD_out[31:0], AD_oe                         - read data path  |
// |            DEVSEL, TRDY, STOP                          - target control  |
// |            PAR, PAR_oe           - only with PCI_CFG_PARITY_EN defined   |
// | Options  : PCI_CFG_PARITY_EN adds read-data parity generation.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pci_config_target #(
   parameter int          CFG_DWORDS  = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [15:0] VENDOR_ID   = 16'h1234,
   parameter logic [15:0] DEVICE_ID   = 16'hABCD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        FRAME,
   input  logic        IRDY,
   input  logic        IDSEL,
   input  logic [3:0]  CBE,
   input  logic [31:0] AD_in,
   output logic [31:0] AD_out,
   output logic        AD_oe,
   output logic        DEVSEL,
   output logic        TRDY,
   output logic        STOP
`ifdef PCI_CFG_PARITY_EN
   ,
   output logic        PAR,
   output logic        PAR_oe
`endif
);

   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_claim    = 3'd1;
   localparam logic [2:0] c_st_wait     = 3'd2;
   localparam logic [2:0] c_st_data     = 3'd3;
   localparam logic [2:0] c_st_turn     = 3'd4;
   localparam logic [2:0] c_st_bus_busy = 3'd5;

   localparam logic [3:0] c_cmd_cfg_rd  = 4'b1010;
   localparam logic [3:0] c_cmd_cfg_wr  = 4'b1011;

   // WAIT is entered from CLAIM, so the counter starts one below the count.
   localparam logic [2:0] c_wait_init   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   logic [2:0]  r_state;
   logic [2:0]  r_wait_cnt;
   logic        r_is_write;
   logic [5:0]  r_index;
   logic        r_devsel_n;
   logic        r_trdy_n;
   logic        r_stop_n;
   logic        r_ad_oe;
   logic [31:0] r_ad_out;
   logic [31:0] r_cfg [1:CFG_DWORDS-1];

   logic        w_claim;
   logic        w_xfer;
   logic [31:0] w_rd_data;

   assign w_claim = IDSEL && ((CBE == c_cmd_cfg_rd) || (CBE == c_cmd_cfg_wr)) &&
                    (AD_in[1:0] == 2'b00);

   // TRDY is registered, so being in DATA means TRDY is low on the bus.
   assign w_xfer  = (r_state == c_st_data) && !IRDY;

   always_comb begin
      w_rd_data = 32'h0;
      if (r_index == 6'd0) begin
         w_rd_data = {DEVICE_ID, VENDOR_ID};
      end
      for (int i = 1; i < CFG_DWORDS; i++) begin
         if (r_index == 6'(i)) begin
            w_rd_data = r_cfg[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_st_idle;
         r_wait_cnt <= 3'd0;
         r_is_write <= 1'b0;
         r_index    <= 6'd0;
         r_devsel_n <= 1'b1;
         r_trdy_n   <= 1'b1;
         r_stop_n   <= 1'b1;
         r_ad_oe    <= 1'b0;
         r_ad_out   <= 32'h0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (!FRAME) begin
                  if (w_claim) begin
                     r_state    <= c_st_claim;
                     r_devsel_n <= 1'b0;
                     r_is_write <= CBE[0];
                     r_index    <= AD_in[7:2];
                  end else begin
                     r_state <= c_st_bus_busy;
                  end
               end
            end

            // Cycle belongs to someone else (or nobody): stay silent until bus idle.
            c_st_bus_busy: begin
               if (FRAME && IRDY) begin
                  r_state <= c_st_idle;
               end
            end

            // Turnaround cycle; read data is captured here and driven from A+2.
            c_st_claim: begin
               r_ad_oe <= ~r_is_write;
               if (!r_is_write) begin
                  r_ad_out <= w_rd_data;
               end
               if (WAIT_STATES == 0) begin
                  r_state  <= c_st_data;
                  r_trdy_n <= 1'b0;
                  r_stop_n <= FRAME;
               end else begin
                  r_state    <= c_st_wait;
                  r_wait_cnt <= c_wait_init;
               end
            end

            c_st_wait: begin
               if (r_wait_cnt == 3'd0) begin
                  r_state  <= c_st_data;
                  r_trdy_n <= 1'b0;
                  r_stop_n <= FRAME;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 3'd1;
               end
            end

            // FRAME still low means a burst: disconnect with data on this phase,
            // then keep DEVSEL/STOP asserted until the initiator drops FRAME.
            c_st_data: begin
               if (!IRDY) begin
                  r_state    <= c_st_turn;
                  r_trdy_n   <= 1'b1;
                  r_ad_oe    <= 1'b0;
                  r_devsel_n <= FRAME;
                  r_stop_n   <= FRAME;
               end else begin
                  r_stop_n <= r_stop_n & FRAME;
               end
            end

            c_st_turn: begin
               if (r_stop_n || FRAME) begin
                  r_state    <= c_st_idle;
                  r_devsel_n <= 1'b1;
                  r_stop_n   <= 1'b1;
               end
            end

            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // Dword 0 is the hard-wired ID and has no storage; indices beyond the
   // array match no entry, so those writes fall away.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < CFG_DWORDS; i++) begin
            r_cfg[i] <= 32'h0;
         end
      end else if (w_xfer && r_is_write) begin
         for (int i = 1; i < CFG_DWORDS; i++) begin
            if (r_index == 6'(i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (!CBE[b]) begin
                     r_cfg[i][8*b +: 8] <= AD_in[8*b +: 8];
                  end
               end
            end
         end
      end
   end

`ifdef PCI_CFG_PARITY_EN
   logic r_par;
   logic r_par_oe;

   // Parity trails its data phase by one clock and covers AD plus byte enables.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_par    <= 1'b0;
         r_par_oe <= 1'b0;
      end else begin
         r_par_oe <= w_xfer && !r_is_write;
         if (w_xfer && !r_is_write) begin
            r_par <= ^{r_ad_out, CBE};
         end
      end
   end

   assign PAR    = r_par;
   assign PAR_oe = r_par_oe;
`endif

   assign AD_out = r_ad_out;
   assign AD_oe  = r_ad_oe;
   assign DEVSEL = r_devsel_n;
   assign TRDY   = r_trdy_n;
   assign STOP   = r_stop_n;

endmodule
`default_nettype wire

// File: tb/tb_pci_config_target.sv
`default_nettype none
// Directed bench for pci_config_target: a zero-wait-state instance driven from a
// transaction table, and a three-wait-state instance for the timing corner cases.
module tb_pci_config_target;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        FRAME, IRDY, FRAME3, IRDY3, IDSEL;
   logic [3:0]  CBE;
   logic [31:0] AD_in;

   logic [31:0] AD_out, AD_out3;
   logic        AD_oe, DEVSEL, TRDY, STOP;
   logic        AD_oe3, DEVSEL3, TRDY3, STOP3;
`ifdef PCI_CFG_PARITY_EN
   logic        PAR, PAR_oe, PAR3, PAR_oe3;
`endif

   pci_config_target #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .FRAME(FRAME), .IRDY(IRDY), .IDSEL(IDSEL),
      .CBE(CBE), .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe),
      .DEVSEL(DEVSEL), .TRDY(TRDY), .STOP(STOP)
`ifdef PCI_CFG_PARITY_EN
      , .PAR(PAR), .PAR_oe(PAR_oe)
`endif
   );

   pci_config_target #(.WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .FRAME(FRAME3), .IRDY(IRDY3), .IDSEL(IDSEL),
      .CBE(CBE), .AD_in(AD_in), .AD_out(AD_out3), .AD_oe(AD_oe3),
      .DEVSEL(DEVSEL3), .TRDY(TRDY3), .STOP(STOP3)
`ifdef PCI_CFG_PARITY_EN
      , .PAR(PAR3), .PAR_oe(PAR_oe3)
`endif
   );

   // Selects which instance the transaction task talks to.
   logic        cur;
   logic        m_devsel, m_trdy, m_stop, m_ad_oe;
   logic [31:0] m_ad_out;
   assign m_devsel = cur ? DEVSEL3 : DEVSEL;
   assign m_trdy   = cur ? TRDY3   : TRDY;
   assign m_stop   = cur ? STOP3   : STOP;
   assign m_ad_oe  = cur ? AD_oe3  : AD_oe;
   assign m_ad_out = cur ? AD_out3 : AD_out;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_frame(input logic v);
      if (cur) FRAME3 = v; else FRAME = v;
   endtask

   task automatic set_irdy(input logic v);
      if (cur) IRDY3 = v; else IRDY = v;
   endtask

   // Entered at a negedge; drives the address phase at once and returns at the
   // negedge where the next address phase may be driven.
   task automatic tx(input string tag, input logic sel, input logic [3:0] cmd,
                     input logic idsel, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic claim, input logic chk_rd,
                     input logic [31:0] exp_rd, input int irdy_extra, input logic burst,
                     input int hold_turn);
      int ws;
      cur = sel;
      ws  = sel ? 3 : 0;
      set_frame(1'b0); set_irdy(1'b1);
      IDSEL = idsel; CBE = cmd; AD_in = addr;
      @(negedge clk);
      if (!claim) begin
         chk({tag, " abort devsel A+1"}, m_devsel, 1'b1);
         set_frame(1'b1); set_irdy(1'b0); CBE = be; AD_in = wdata;
         repeat (2) begin
            @(negedge clk);
            chk({tag, " abort devsel"}, m_devsel, 1'b1);
            chk({tag, " abort trdy"},   m_trdy,   1'b1);
            chk({tag, " abort stop"},   m_stop,   1'b1);
            chk({tag, " abort ad_oe"},  m_ad_oe,  1'b0);
         end
         set_irdy(1'b1);
         @(negedge clk);
         return;
      end
      chk({tag, " devsel A+1"}, m_devsel, 1'b0);
      chk({tag, " trdy A+1"},   m_trdy,   1'b1);
      chk({tag, " ad_oe A+1"},  m_ad_oe,  1'b0);
      set_frame(burst ? 1'b0 : 1'b1); set_irdy(irdy_extra > 0);
      CBE = be; AD_in = wdata;
      for (int k = 0; k < ws; k++) begin
         @(negedge clk);
         chk({tag, " trdy wait"},   m_trdy,   1'b1);
         chk({tag, " devsel wait"}, m_devsel, 1'b0);
      end
      @(negedge clk);
      chk({tag, " trdy data"},   m_trdy,   1'b0);
      chk({tag, " devsel data"}, m_devsel, 1'b0);
      chk({tag, " stop data"},   m_stop,   !burst);
      chk({tag, " ad_oe data"},  m_ad_oe,  !cmd[0]);
      if (chk_rd) chk({tag, " rdata"}, m_ad_out, exp_rd);
      for (int k = 0; k < irdy_extra; k++) begin
         @(negedge clk);
         chk({tag, " trdy hold"},   m_trdy,   1'b0);
         chk({tag, " devsel hold"}, m_devsel, 1'b0);
         if (chk_rd) chk({tag, " rdata hold"}, m_ad_out, exp_rd);
      end
      set_irdy(1'b0);
      @(negedge clk);
      chk({tag, " trdy after"},  m_trdy,  1'b1);
      chk({tag, " ad_oe after"}, m_ad_oe, 1'b0);
`ifdef PCI_CFG_PARITY_EN
      if (!cmd[0]) begin
         chk({tag, " par"},    sel ? PAR3 : PAR, ^{exp_rd, be});
         chk({tag, " par_oe"}, sel ? PAR_oe3 : PAR_oe, 1'b1);
      end
`endif
      if (burst) begin
         chk({tag, " stop turn"},   m_stop,   1'b0);
         chk({tag, " devsel turn"}, m_devsel, 1'b0);
         for (int k = 0; k < hold_turn; k++) begin
            @(negedge clk);
            chk({tag, " stop hold"},   m_stop,   1'b0);
            chk({tag, " devsel hold"}, m_devsel, 1'b0);
            chk({tag, " trdy turn"},   m_trdy,   1'b1);
         end
         set_frame(1'b1);
         @(negedge clk);
         chk({tag, " stop end"},   m_stop,   1'b1);
         chk({tag, " devsel end"}, m_devsel, 1'b1);
         set_irdy(1'b1);
      end else begin
         chk({tag, " stop after"},   m_stop,   1'b1);
         chk({tag, " devsel after"}, m_devsel, 1'b1);
         set_irdy(1'b1);
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic        idsel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        claim;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   initial begin
      vecs[0]  = '{4'hA, 1'b1, 32'h04, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
      vecs[1]  = '{4'hA, 1'b1, 32'h00, 32'h0,        4'h0, 1'b1, 1'b1, 32'hABCD1234};
      vecs[2]  = '{4'hB, 1'b1, 32'h00, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{4'hA, 1'b1, 32'h00, 32'h0,        4'h0, 1'b1, 1'b1, 32'hABCD1234};
      vecs[4]  = '{4'hB, 1'b1, 32'h04, 32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 32'h0};
      vecs[5]  = '{4'hA, 1'b1, 32'h04, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEADBEEF};
      vecs[6]  = '{4'hB, 1'b1, 32'h04, 32'h0,        4'hC, 1'b1, 1'b0, 32'h0};
      vecs[7]  = '{4'hA, 1'b1, 32'h04, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD0000};
      vecs[8]  = '{4'hA, 1'b0, 32'h04, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
      vecs[9]  = '{4'h6, 1'b1, 32'h04, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{4'hA, 1'b1, 32'h04, 32'h0,        4'h0, 1'b1, 1'b1, 32'hDEAD0000};
      vecs[11] = '{4'hB, 1'b1, 32'h3C, 32'h12345678, 4'h5, 1'b1, 1'b0, 32'h0};
      vecs[12] = '{4'hA, 1'b1, 32'h3C, 32'h0,        4'h0, 1'b1, 1'b1, 32'h12005600};
      vecs[13] = '{4'hB, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 32'h0};
      vecs[14] = '{4'hA, 1'b1, 32'h40, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
      vecs[15] = '{4'hB, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0};
      vecs[16] = '{4'hA, 1'b1, 32'h08, 32'h0,        4'h0, 1'b1, 1'b1, 32'h0};
      vecs[17] = '{4'hA, 1'b1, 32'h05, 32'h0,        4'h0, 1'b0, 1'b0, 32'h0};

      cur = 1'b0;
      rst_n = 1'b0; FRAME = 1'b1; IRDY = 1'b1; FRAME3 = 1'b1; IRDY3 = 1'b1;
      IDSEL = 1'b0; CBE = 4'hF; AD_in = 32'h0;
      repeat (2) @(negedge clk);
      chk("reset devsel", DEVSEL, 1'b1);
      chk("reset trdy",   TRDY,   1'b1);
      chk("reset stop",   STOP,   1'b1);
      chk("reset ad_oe",  AD_oe,  1'b0);
      chk("reset ad_out", AD_out, 32'h0);
      chk("reset devsel3", DEVSEL3, 1'b1);
      chk("reset trdy3",   TRDY3,   1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         tx($sformatf("v%0d", i), 1'b0, vecs[i].cmd, vecs[i].idsel, vecs[i].addr,
            vecs[i].wdata, vecs[i].be, vecs[i].claim, vecs[i].chk_rd, vecs[i].exp_rd,
            0, 1'b0, 0);
      end

      // Burst read on the zero-wait target: disconnect with data, hold in turnaround.
      tx("burst0", 1'b0, 4'hA, 1'b1, 32'h04, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEAD0000, 0, 1'b1, 1);
      tx("after_burst0", 1'b0, 4'hA, 1'b1, 32'h3C, 32'h0, 4'h0, 1'b1, 1'b1, 32'h12005600, 0, 1'b0, 0);

      // Three wait states, initiator late by two cycles, then a burst read-back.
      tx("ws3_wr", 1'b1, 4'hB, 1'b1, 32'h08, 32'h0BADF00D, 4'h0, 1'b1, 1'b0, 32'h0, 2, 1'b0, 0);
      tx("ws3_rd", 1'b1, 4'hA, 1'b1, 32'h08, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0BADF00D, 0, 1'b1, 0);
      tx("ws3_id", 1'b1, 4'hA, 1'b1, 32'h00, 32'h0, 4'h0, 1'b1, 1'b1, 32'hABCD1234, 1, 1'b0, 0);

      // Reset lands on the turnaround cycle of a write: nothing may be written.
      cur = 1'b0;
      FRAME = 1'b0; IRDY = 1'b1; IDSEL = 1'b1; CBE = 4'hB; AD_in = 32'h08;
      @(negedge clk);
      chk("rstmid devsel A+1", DEVSEL, 1'b0);
      FRAME = 1'b1; IRDY = 1'b0; CBE = 4'h0; AD_in = 32'hCAFEF00D; rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid devsel", DEVSEL, 1'b1);
      chk("rstmid trdy",   TRDY,   1'b1);
      chk("rstmid stop",   STOP,   1'b1);
      chk("rstmid ad_oe",  AD_oe,  1'b0);
      chk("rstmid ad_out", AD_out, 32'h0);
      rst_n = 1'b1; IRDY = 1'b1;
      @(negedge clk);
      tx("rstmid_rd08", 1'b0, 4'hA, 1'b1, 32'h08, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 0, 1'b0, 0);
      tx("rstmid_rd04", 1'b0, 4'hA, 1'b1, 32'h04, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 0, 1'b0, 0);

`ifdef PCI_CFG_PARITY_EN
      tx("par_wr", 1'b0, 4'hB, 1'b1, 32'h0C, 32'h00000001, 4'h0, 1'b1, 1'b0, 32'h0, 0, 1'b0, 0);
      tx("par_rd", 1'b0, 4'hA, 1'b1, 32'h0C, 32'h0, 4'h0, 1'b1, 1'b1, 32'h00000001, 0, 1'b0, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
